// File: rtl/cache_pkg.sv
// Shared encodings for the L1 data-cache control path.
//   Op codes   : request/transaction operations, same encodings as the
//                metadata next-state logic (LD/ST from the core side,
//                RD/WR/RWITM toward L2, INV/UPD for coherence updates).
//   mshr_state_e: life cycle of one miss-status entry.
package cache_pkg;

    localparam logic [2:0] NO_OP = 3'd0;
    localparam logic [2:0] LD    = 3'd1;
    localparam logic [2:0] ST    = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] WR    = 3'd4;
    localparam logic [2:0] INV   = 3'd5;
    localparam logic [2:0] UPD   = 3'd6;
    localparam logic [2:0] RWITM = 3'd7;

    typedef enum logic [2:0] {
        FREE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FILL    = 3'd5
    } mshr_state_e;

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter with one-hot grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request bitmap
//   ack        : the current grant was consumed this cycle; the pointer
//                moves to granted+1 mod N
//   lock       : the current grant is stalled; next cycle repeats it
//                regardless of new requests
//   grant      : one-hot grant (all zero when nothing requests)
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    input  logic         lock,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic          lock_q;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  hi_pick, lo_pick;
    logic          hi_found, lo_found;

    // First requester at or above the pointer wins; otherwise wrap to the
    // lowest requester overall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        gnt_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && IW'(i) >= ptr && !hi_found) begin
                hi_pick[i] = 1'b1;
                hi_found   = 1'b1;
            end
            if (req[i] && !lo_found) begin
                lo_pick[i] = 1'b1;
                lo_found   = 1'b1;
            end
        end
        grant = lock_q ? grant_q : (hi_found ? hi_pick : lo_pick);
        for (int i = 0; i < N; i++) begin
            if (grant[i]) gnt_idx = IW'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            lock_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            lock_q  <= lock;
            grant_q <= grant;
            if (ack) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/miss_ctrl.sv
// L1 data-cache miss-handling controller.
// Owns N_MSHR miss entries; each sequences an optional dirty-victim
// writeback, the line read to L2, then the fill handback to the arrays.
//   alloc_*     : allocation from the tag pipeline (valid/ready handshake)
//   lookup_addr : tag-pipeline probe; mshr_hit flags an outstanding line
//   l2_req_*    : request channel to L2 (round-robin, locked while stalled)
//   l2_resp_*   : L2 completion by entry id
//   fill_*      : fill to meta/data arrays (lowest FILL index, held while stalled)
//   resp_err    : sticky, a response arrived for an entry not waiting on one
//   busy        : per-entry non-FREE bitmap
module miss_ctrl
    import cache_pkg::*;
#(
    parameter int N_MSHR   = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int ID_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [2:0]        alloc_op,
    input  logic [3:0]        alloc_way,
    input  logic              alloc_wb,
    input  logic [ADDR_W-1:0] alloc_victim_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              mshr_hit,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [2:0]        l2_req_op,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [ID_W-1:0]   l2_req_id,
    input  logic              l2_resp_valid,
    input  logic [ID_W-1:0]   l2_resp_id,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [ID_W-1:0]   fill_id,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [3:0]        fill_way,
    output logic [2:0]        fill_op,
    output logic              resp_err,
    output logic [N_MSHR-1:0] busy
);

    localparam int LINE_W = ADDR_W - OFFSET_W;

    mshr_state_e       st        [N_MSHR];
    logic [LINE_W-1:0] miss_line [N_MSHR];
    logic [LINE_W-1:0] vict_line [N_MSHR];
    logic [2:0]        op_q      [N_MSHR];
    logic [3:0]        way_q     [N_MSHR];

    logic              ready_en;
    logic              fill_hold_q;
    logic [ID_W-1:0]   fill_hold_id;
    logic [N_MSHR-1:0] req_vec, fill_vec, grant;
    logic [ID_W-1:0]   alloc_idx, gnt_idx, fill_pick, fill_idx;
    logic              free_any, alloc_match, hit_any;
    logic              alloc_fire, l2_hs, fill_hs, resp_ok;
    logic              unused_offsets;

    assign unused_offsets = ^{alloc_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0],
                              alloc_victim_addr[OFFSET_W-1:0]};

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        busy        = '0;
        req_vec     = '0;
        fill_vec    = '0;
        free_any    = 1'b0;
        alloc_match = 1'b0;
        hit_any     = 1'b0;
        alloc_idx   = '0;
        fill_pick   = '0;
        gnt_idx     = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            busy[i]    = (st[i] != FREE);
            req_vec[i] = (st[i] == WB_REQ) || (st[i] == RD_REQ);
            if (st[i] == FREE) begin
                free_any  = 1'b1;
                alloc_idx = ID_W'(i);
            end
            if (st[i] == FILL) begin
                fill_vec[i] = 1'b1;
                fill_pick   = ID_W'(i);
            end
            if (st[i] != FREE && miss_line[i] == alloc_addr[ADDR_W-1:OFFSET_W])  alloc_match = 1'b1;
            if (st[i] != FREE && miss_line[i] == lookup_addr[ADDR_W-1:OFFSET_W]) hit_any     = 1'b1;
            if (grant[i]) gnt_idx = ID_W'(i);
        end
    end

    // ready_en keeps alloc_ready low while in reset and for the first
    // cycle after it, so every output reads 0 during reset.
    assign alloc_ready = ready_en && free_any && !alloc_match;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign mshr_hit    = hit_any;

    rr_arb #(.N(N_MSHR)) u_req_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .ack   (l2_hs),
        .lock  (l2_req_valid && !l2_req_ready),
        .grant (grant)
    );

    assign l2_req_valid = |grant;
    assign l2_hs        = l2_req_valid && l2_req_ready;

    always_comb begin
        l2_req_op   = NO_OP;
        l2_req_addr = '0;
        l2_req_id   = '0;
        if (l2_req_valid) begin
            l2_req_id = gnt_idx;
            if (st[gnt_idx] == WB_REQ) begin
                l2_req_op   = WR;
                l2_req_addr = {vict_line[gnt_idx], {OFFSET_W{1'b0}}};
            end else begin
                l2_req_op   = (op_q[gnt_idx] == ST) ? RWITM : RD;
                l2_req_addr = {miss_line[gnt_idx], {OFFSET_W{1'b0}}};
            end
        end
    end

    // A stalled fill keeps its id even if a lower index reaches FILL.
    assign fill_idx   = fill_hold_q ? fill_hold_id : fill_pick;
    assign fill_valid = |fill_vec;
    assign fill_hs    = fill_valid && fill_ready;
    assign fill_id    = fill_valid ? fill_idx : '0;
    assign fill_addr  = fill_valid ? {miss_line[fill_idx], {OFFSET_W{1'b0}}} : '0;
    assign fill_way   = fill_valid ? way_q[fill_idx] : '0;
    assign fill_op    = fill_valid ? op_q[fill_idx] : NO_OP;

    assign resp_ok = (st[l2_resp_id] == WB_WAIT) || (st[l2_resp_id] == RD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MSHR; i++) st[i] <= FREE;
            ready_en     <= 1'b0;
            resp_err     <= 1'b0;
            fill_hold_q  <= 1'b0;
            fill_hold_id <= '0;
        end else begin
            ready_en     <= 1'b1;
            fill_hold_q  <= fill_valid && !fill_ready;
            fill_hold_id <= fill_idx;
            if (l2_resp_valid && !resp_ok) resp_err <= 1'b1;
            for (int i = 0; i < N_MSHR; i++) begin
                case (st[i])
                    FREE:    if (alloc_fire && alloc_idx == ID_W'(i))
                                 st[i] <= alloc_wb ? WB_REQ : RD_REQ;
                    WB_REQ:  if (l2_hs && gnt_idx == ID_W'(i)) st[i] <= WB_WAIT;
                    WB_WAIT: if (l2_resp_valid && l2_resp_id == ID_W'(i)) st[i] <= RD_REQ;
                    RD_REQ:  if (l2_hs && gnt_idx == ID_W'(i)) st[i] <= RD_WAIT;
                    RD_WAIT: if (l2_resp_valid && l2_resp_id == ID_W'(i)) st[i] <= FILL;
                    FILL:    if (fill_hs && fill_idx == ID_W'(i)) st[i] <= FREE;
                    default: st[i] <= FREE;
                endcase
            end
        end
    end

    // NOTE: entry payload has no reset; it is only read while the entry's
    // state is non-FREE, and allocation always writes it first.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            miss_line[alloc_idx] <= alloc_addr[ADDR_W-1:OFFSET_W];
            vict_line[alloc_idx] <= alloc_victim_addr[ADDR_W-1:OFFSET_W];
            op_q[alloc_idx]      <= alloc_op;
            way_q[alloc_idx]     <= alloc_way;
        end
    end

endmodule

// File: tb/tb_miss_ctrl.sv
// Directed bench for miss_ctrl. Inputs are driven just after the rising
// edge, outputs are checked on the falling edge.
module tb_miss_ctrl;

    logic        clk, rst_n;
    logic        alloc_valid, alloc_ready, alloc_wb;
    logic [31:0] alloc_addr, alloc_victim_addr, lookup_addr;
    logic [2:0]  alloc_op;
    logic [3:0]  alloc_way;
    logic        mshr_hit;
    logic        l2_req_valid, l2_req_ready;
    logic [2:0]  l2_req_op;
    logic [31:0] l2_req_addr;
    logic [1:0]  l2_req_id;
    logic        l2_resp_valid;
    logic [1:0]  l2_resp_id;
    logic        fill_valid, fill_ready;
    logic [1:0]  fill_id;
    logic [31:0] fill_addr;
    logic [3:0]  fill_way;
    logic [2:0]  fill_op;
    logic        resp_err;
    logic [3:0]  busy;

    int total = 0;
    int bad   = 0;

    miss_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .alloc_op(alloc_op), .alloc_way(alloc_way), .alloc_wb(alloc_wb),
        .alloc_victim_addr(alloc_victim_addr), .lookup_addr(lookup_addr), .mshr_hit(mshr_hit),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_op(l2_req_op),
        .l2_req_addr(l2_req_addr), .l2_req_id(l2_req_id),
        .l2_resp_valid(l2_resp_valid), .l2_resp_id(l2_resp_id),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_id(fill_id),
        .fill_addr(fill_addr), .fill_way(fill_way), .fill_op(fill_op),
        .resp_err(resp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // {valid, op, addr, id}
    function automatic logic [37:0] l2_vec();
        return {l2_req_valid, l2_req_op, l2_req_addr, l2_req_id};
    endfunction

    // {valid, id, addr, way, op}
    function automatic logic [41:0] fill_vec();
        return {fill_valid, fill_id, fill_addr, fill_way, fill_op};
    endfunction

    function automatic logic [86:0] all_out();
        return {alloc_ready, mshr_hit, l2_vec(), fill_vec(), resp_err, busy};
    endfunction

    task automatic do_alloc(input logic [31:0] addr, input logic [2:0] op,
                            input logic [3:0] way, input logic wb, input logic [31:0] vict);
        alloc_valid = 1'b1; alloc_addr = addr; alloc_op = op;
        alloc_way = way; alloc_wb = wb; alloc_victim_addr = vict;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (all_out() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out()); end
        @(negedge clk); rst_n = 1'b1;
        step(); step();
        mid();
        total++;
        if ({alloc_ready, busy, l2_req_valid, fill_valid, resp_err} !== 8'b1_0000_000) begin
            bad++; $display("FAIL post_reset got=%b exp=10000000",
                            {alloc_ready, busy, l2_req_valid, fill_valid, resp_err});
        end
        step();
    endtask

    task automatic test_ld_miss();
        l2_req_ready = 1'b1; fill_ready = 1'b1;
        do_alloc(32'h1040, 3'd1, 4'b0010, 1'b0, 32'h0);
        mid();                                                    // cycle 0
        total++;
        if ({alloc_ready, l2_req_valid} !== 2'b10) begin
            bad++; $display("FAIL t1_alloc got=%b exp=10", {alloc_ready, l2_req_valid});
        end
        step(); alloc_valid = 1'b0;
        mid();                                                    // cycle 1
        total++;
        if (l2_vec() !== {1'b1, 3'd3, 32'h1040, 2'd0}) begin
            bad++; $display("FAIL t1_l2_req got=%h exp=%h", l2_vec(), {1'b1, 3'd3, 32'h1040, 2'd0});
        end
        step(); mid();                                            // cycle 2
        total++;
        if ({l2_req_valid, busy} !== 5'b0_0001) begin
            bad++; $display("FAIL t1_wait got=%b exp=00001", {l2_req_valid, busy});
        end
        step(); step(); l2_resp_valid = 1'b1; l2_resp_id = 2'd0;  // cycle 4
        mid();
        total++;
        if (fill_valid !== 1'b0) begin bad++; $display("FAIL t1_early_fill got=%b exp=0", fill_valid); end
        step(); l2_resp_valid = 1'b0;
        mid();                                                    // cycle 5
        total++;
        if (fill_vec() !== {1'b1, 2'd0, 32'h1040, 4'b0010, 3'd1}) begin
            bad++; $display("FAIL t1_fill got=%h exp=%h", fill_vec(), {1'b1, 2'd0, 32'h1040, 4'b0010, 3'd1});
        end
        step(); mid();                                            // cycle 6
        total++;
        if ({busy, fill_valid} !== 5'b0) begin
            bad++; $display("FAIL t1_free got=%b exp=00000", {busy, fill_valid});
        end
        step();
    endtask

    task automatic test_wb_miss();
        l2_req_ready = 1'b1; fill_ready = 1'b1;
        do_alloc(32'h3000, 3'd2, 4'b0100, 1'b1, 32'h2000);
        step(); alloc_valid = 1'b0;
        mid();                                                    // cycle 1
        total++;
        if (l2_vec() !== {1'b1, 3'd4, 32'h2000, 2'd0}) begin
            bad++; $display("FAIL t2_wr got=%h exp=%h", l2_vec(), {1'b1, 3'd4, 32'h2000, 2'd0});
        end
        step(); mid();                                            // cycle 2
        total++;
        if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL t2_no_rd_before_resp got=%b exp=0", l2_req_valid); end
        step(); l2_resp_valid = 1'b1; l2_resp_id = 2'd0;          // cycle 3
        mid();
        total++;
        if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL t2_wait got=%b exp=0", l2_req_valid); end
        step(); l2_req_ready = 1'b0;                              // cycle 4, stray resp
        mid();
        total++;
        if ({l2_vec(), resp_err} !== {1'b1, 3'd7, 32'h3000, 2'd0, 1'b0}) begin
            bad++; $display("FAIL t2_rwitm got=%h exp=%h", {l2_vec(), resp_err}, {1'b1, 3'd7, 32'h3000, 2'd0, 1'b0});
        end
        step(); l2_resp_valid = 1'b0; l2_req_ready = 1'b1;        // cycle 5
        mid();
        total++;
        if ({resp_err, l2_vec()} !== {1'b1, 1'b1, 3'd7, 32'h3000, 2'd0}) begin
            bad++; $display("FAIL t2_resp_err got=%h exp=%h", {resp_err, l2_vec()}, {1'b1, 1'b1, 3'd7, 32'h3000, 2'd0});
        end
        step(); l2_resp_valid = 1'b1; l2_resp_id = 2'd0;          // cycle 6
        step(); l2_resp_valid = 1'b0;
        mid();                                                    // cycle 7
        total++;
        if (fill_vec() !== {1'b1, 2'd0, 32'h3000, 4'b0100, 3'd2}) begin
            bad++; $display("FAIL t2_fill got=%h exp=%h", fill_vec(), {1'b1, 2'd0, 32'h3000, 4'b0100, 3'd2});
        end
        step(); mid();
        total++;
        if (busy !== 4'b0) begin bad++; $display("FAIL t2_free got=%b exp=0000", busy); end
        step();
    endtask

    task automatic test_back_to_back();
        fill_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            l2_req_ready = 1'b0;
            if (c < 5) do_alloc(32'h4000 + 32'(c) * 32'h1000, 3'd1, 4'b0001, 1'b0, 32'h0);
            else alloc_valid = 1'b0;
            mid();
            if (c < 4) begin
                total++;
                if (alloc_ready !== 1'b1) begin bad++; $display("FAIL t3_alloc_ready c=%0d got=%b exp=1", c, alloc_ready); end
            end
            if (c == 4) begin
                total++;
                if ({alloc_ready, busy} !== 5'b0_1111) begin
                    bad++; $display("FAIL t3_full got=%b exp=01111", {alloc_ready, busy});
                end
            end
            if (c >= 1) begin
                total++;
                if (l2_vec() !== {1'b1, 3'd3, 32'h4000, 2'd0}) begin
                    bad++; $display("FAIL t3_stable c=%0d got=%h exp=%h", c, l2_vec(), {1'b1, 3'd3, 32'h4000, 2'd0});
                end
            end
            step();
        end
        alloc_valid = 1'b0; l2_req_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            mid();
            total++;
            if (l2_vec() !== {1'b1, 3'd3, 32'h4000 + 32'(g) * 32'h1000, 2'(g)}) begin
                bad++; $display("FAIL t3_rr g=%0d got=%h exp=%h", g, l2_vec(),
                                {1'b1, 3'd3, 32'h4000 + 32'(g) * 32'h1000, 2'(g)});
            end
            step();
        end
        for (int k = 0; k < 5; k++) begin
            l2_resp_valid = (k < 4); l2_resp_id = 2'(k);
            mid();
            if (k > 0) begin
                total++;
                if (fill_vec() !== {1'b1, 2'(k - 1), 32'h4000 + 32'(k - 1) * 32'h1000, 4'b0001, 3'd1}) begin
                    bad++; $display("FAIL t3_fill k=%0d got=%h", k, fill_vec());
                end
            end
            step();
        end
        l2_resp_valid = 1'b0;
        mid();
        total++;
        if (busy !== 4'b0) begin bad++; $display("FAIL t3_drain got=%b exp=0000", busy); end
        step();
    endtask

    task automatic test_hit();
        l2_req_ready = 1'b1; fill_ready = 1'b1;
        do_alloc(32'h1040, 3'd1, 4'b0001, 1'b0, 32'h0);
        step(); alloc_valid = 1'b0;                               // cycle 1 handshake
        step();                                                   // cycle 2: RD_WAIT
        lookup_addr = 32'h1058;
        do_alloc(32'h1070, 3'd1, 4'b0010, 1'b0, 32'h0);
        mid();
        total++;
        if ({mshr_hit, alloc_ready} !== 2'b10) begin
            bad++; $display("FAIL t4_hit got=%b exp=10", {mshr_hit, alloc_ready});
        end
        step(); alloc_valid = 1'b0; lookup_addr = 32'h2040;
        l2_resp_valid = 1'b1; l2_resp_id = 2'd0;
        mid();
        total++;
        if ({mshr_hit, busy} !== 5'b0_0001) begin
            bad++; $display("FAIL t4_miss_refused got=%b exp=00001", {mshr_hit, busy});
        end
        step(); l2_resp_valid = 1'b0;
        step(); mid();
        total++;
        if (busy !== 4'b0) begin bad++; $display("FAIL t4_free got=%b exp=0000", busy); end
        step();
    endtask

    task automatic test_simultaneous();
        l2_req_ready = 1'b1; fill_ready = 1'b0;
        do_alloc(32'h9000, 3'd1, 4'b0001, 1'b0, 32'h0);           // entry 0
        step();
        do_alloc(32'hA000, 3'd1, 4'b0010, 1'b0, 32'h0);           // entry 1
        step(); alloc_valid = 1'b0;                               // cycle 2
        step(); l2_resp_valid = 1'b1; l2_resp_id = 2'd1;          // cycle 3
        step();                                                   // cycle 4
        l2_resp_valid = 1'b1; l2_resp_id = 2'd0;
        do_alloc(32'hB000, 3'd2, 4'b1000, 1'b0, 32'h0);           // entry 2
        mid();
        total++;
        if ({fill_vec(), alloc_ready} !== {1'b1, 2'd1, 32'hA000, 4'b0010, 3'd1, 1'b1}) begin
            bad++; $display("FAIL t5_before got=%h", {fill_vec(), alloc_ready});
        end
        step(); alloc_valid = 1'b0; l2_resp_valid = 1'b0; fill_ready = 1'b1;   // cycle 5
        mid();
        total++;
        if (fill_vec() !== {1'b1, 2'd1, 32'hA000, 4'b0010, 3'd1}) begin
            bad++; $display("FAIL t5_fill_held got=%h exp=%h", fill_vec(), {1'b1, 2'd1, 32'hA000, 4'b0010, 3'd1});
        end
        total++;
        if ({busy, l2_vec()} !== {4'b0111, 1'b1, 3'd7, 32'hB000, 2'd2}) begin
            bad++; $display("FAIL t5_others got=%h exp=%h", {busy, l2_vec()}, {4'b0111, 1'b1, 3'd7, 32'hB000, 2'd2});
        end
        step(); l2_resp_valid = 1'b1; l2_resp_id = 2'd2;          // cycle 6
        mid();
        total++;
        if (fill_vec() !== {1'b1, 2'd0, 32'h9000, 4'b0001, 3'd1}) begin
            bad++; $display("FAIL t5_fill0 got=%h", fill_vec());
        end
        step(); l2_resp_valid = 1'b0;
        mid();                                                    // cycle 7
        total++;
        if (fill_vec() !== {1'b1, 2'd2, 32'hB000, 4'b1000, 3'd2}) begin
            bad++; $display("FAIL t5_fill2 got=%h", fill_vec());
        end
        step(); mid();
        total++;
        if (busy !== 4'b0) begin bad++; $display("FAIL t5_free got=%b exp=0000", busy); end
        step();
    endtask

    task automatic test_async_reset();
        l2_req_ready = 1'b1; fill_ready = 1'b0;
        do_alloc(32'hD000, 3'd1, 4'b0001, 1'b1, 32'hC000);        // entry 0, dirty victim
        step();
        do_alloc(32'hE000, 3'd1, 4'b0010, 1'b0, 32'h0);           // entry 1
        step(); alloc_valid = 1'b0;
        l2_resp_valid = 1'b1; l2_resp_id = 2'd3;                  // stray: entry 3 is FREE
        step(); l2_resp_id = 2'd1;
        step(); l2_resp_valid = 1'b0;
        lookup_addr = 32'hE000; alloc_addr = 32'hF000;
        mid();
        total++;
        if ({fill_valid, busy, resp_err, mshr_hit, alloc_ready} !== 8'b1_0011_111) begin
            bad++; $display("FAIL t6_setup got=%b exp=10011111",
                            {fill_valid, busy, resp_err, mshr_hit, alloc_ready});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (all_out() !== '0) begin bad++; $display("FAIL t6_async_clear got=%h exp=0", all_out()); end
        @(negedge clk); rst_n = 1'b1; fill_ready = 1'b1;
        step(); step(); mid();
        total++;
        if ({alloc_ready, busy, l2_req_valid, fill_valid, resp_err} !== 8'b1_0000_000) begin
            bad++; $display("FAIL t6_after got=%b exp=10000000",
                            {alloc_ready, busy, l2_req_valid, fill_valid, resp_err});
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_addr = '0; alloc_op = '0; alloc_way = '0;
        alloc_wb = 1'b0; alloc_victim_addr = '0; lookup_addr = '0;
        l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_id = '0; fill_ready = 1'b0;
        test_reset();
        test_ld_miss();
        test_wb_miss();
        test_back_to_back();
        test_hit();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
